// File: rtl/rx_byte_fifo_pkg.sv
// Shared constants and types for the RS232 receive byte FIFO.
package rx_byte_fifo_pkg;

  localparam int DW         = 8;
  localparam int AW_DEFAULT = 3;
  localparam int PERR_W     = 8;
  localparam logic [PERR_W-1:0] PERR_MAX = 8'hFF;

  // One queued entry: received byte plus its parity verdict.
  typedef struct packed {
    logic          ok;
    logic [DW-1:0] data;
  } entry_t;

  function automatic logic [PERR_W-1:0] sat_inc(input logic [PERR_W-1:0] v);
    return (v == PERR_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rx_byte_fifo_ram.sv
// Entry storage for rx_byte_fifo: synchronous write, asynchronous read.
module rx_byte_fifo_ram
  import rx_byte_fifo_pkg::*;
#(
  parameter int AW = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  entry_t        wdata,
  input  logic [AW-1:0] raddr,
  output entry_t        rdata
);

  entry_t mem [2**AW];

  // NOTE: storage has no reset; the top masks the read port while empty.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rx_byte_fifo.sv
// Receive buffer behind the RS232 receiver: captures each end-of-reception into a
// first-word-fall-through FIFO with sticky overflow and parity-error counting.
module rx_byte_fifo
  import rx_byte_fifo_pkg::*;
#(
  parameter int AW       = AW_DEFAULT,
  parameter bit DROP_BAD = 1'b0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EOR,
  input  logic [DW-1:0]     D,
  input  logic              DVD,
  input  logic              RD,
  input  logic              CLR,
  output logic [DW-1:0]     DOUT,
  output logic              DOUT_OK,
  output logic              EMPTY,
  output logic              FULL,
  output logic [AW:0]       COUNT,
  output logic              OVF,
  output logic [PERR_W-1:0] PERR_CNT
);

  localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);

  logic        e1, e2, e3;
  logic        wr, keep, wr_en, rd_en, ovf_evt, perr_evt;
  logic [AW:0] wptr, rptr, wptr_nxt, rptr_nxt, count_nxt;
  entry_t      head;

  // Reset to 1 so an EOR already high when reset releases is not taken as an edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      e1 <= 1'b1;
      e2 <= 1'b1;
      e3 <= 1'b1;
    end else begin
      e1 <= EOR;
      e2 <= e1;
      e3 <= e2;
    end
  end

  assign wr       = e2 & ~e3;
  assign keep     = DVD | ~DROP_BAD;
  assign rd_en    = RD & ~EMPTY;
  assign wr_en    = wr & keep & (~FULL | RD);
  assign ovf_evt  = wr & keep & FULL & ~RD;
  assign perr_evt = wr & ~DVD;

  assign wptr_nxt  = wptr + (AW+1)'(wr_en);
  assign rptr_nxt  = rptr + (AW+1)'(rd_en);
  assign count_nxt = wptr_nxt - rptr_nxt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr  <= '0;
      rptr  <= '0;
      COUNT <= '0;
      EMPTY <= 1'b1;
      FULL  <= 1'b0;
    end else begin
      wptr  <= wptr_nxt;
      rptr  <= rptr_nxt;
      COUNT <= count_nxt;
      EMPTY <= (count_nxt == '0);
      FULL  <= (count_nxt == DEPTH);
    end
  end

  // A same-cycle overflow or parity event takes priority over CLR.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OVF      <= 1'b0;
      PERR_CNT <= '0;
    end else begin
      if (ovf_evt)  OVF <= 1'b1;
      else if (CLR) OVF <= 1'b0;

      if (perr_evt)  PERR_CNT <= CLR ? PERR_W'(1) : sat_inc(PERR_CNT);
      else if (CLR)  PERR_CNT <= '0;
    end
  end

  rx_byte_fifo_ram #(.AW(AW)) u_ram (
    .clk   (CLK),
    .we    (wr_en),
    .waddr (wptr[AW-1:0]),
    .wdata ('{ok: DVD, data: D}),
    .raddr (rptr[AW-1:0]),
    .rdata (head)
  );

  assign DOUT    = EMPTY ? '0   : head.data;
  assign DOUT_OK = EMPTY ? 1'b0 : head.ok;

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Directed bench for rx_byte_fifo; a second instance runs with DROP_BAD=1.
module tb_rx_byte_fifo;

  logic       clk = 1'b0;
  logic       rst, eor, dvd, rd, clr;
  logic [7:0] d;

  logic [7:0] dout_a, perr_a, dout_b, perr_b;
  logic       ok_a, empty_a, full_a, ovf_a, ok_b, empty_b, full_b, ovf_b;
  logic [3:0] count_a, count_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rx_byte_fifo #(.AW(3), .DROP_BAD(1'b0)) dut_a (
    .CLK(clk), .RST(rst), .EOR(eor), .D(d), .DVD(dvd), .RD(rd), .CLR(clr),
    .DOUT(dout_a), .DOUT_OK(ok_a), .EMPTY(empty_a), .FULL(full_a),
    .COUNT(count_a), .OVF(ovf_a), .PERR_CNT(perr_a)
  );

  rx_byte_fifo #(.AW(3), .DROP_BAD(1'b1)) dut_b (
    .CLK(clk), .RST(rst), .EOR(eor), .D(d), .DVD(dvd), .RD(rd), .CLR(clr),
    .DOUT(dout_b), .DOUT_OK(ok_b), .EMPTY(empty_b), .FULL(full_b),
    .COUNT(count_b), .OVF(ovf_b), .PERR_CNT(perr_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; eor = 1'b0; d = '0; dvd = 1'b1; rd = 1'b0; clr = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  // EOR high for 3 edges (write on the 3rd), then low long enough to re-arm.
  task automatic send_byte(input logic [7:0] b, input logic ok, input logic rd_on_wr,
                           input logic clr_on_wr);
    d = b; dvd = ok; eor = 1'b1;
    step();
    step();
    rd = rd_on_wr; clr = clr_on_wr;
    step();
    rd = 1'b0; clr = 1'b0; eor = 1'b0;
    step();
    step();
  endtask

  task automatic pop();
    rd = 1'b1;
    step();
    rd = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; eor = 1'b1; d = 8'h5A; dvd = 1'b1; rd = 1'b0; clr = 1'b0;
    step();
    step();
    rst = 1'b0;
    repeat (5) step();
    total++;
    if (empty_a !== 1'b1 || count_a !== 4'd0 || full_a !== 1'b0) begin
      bad++;
      $display("FAIL reset_eor_high: empty=%b count=%0d full=%b, want 1 0 0", empty_a, count_a, full_a);
    end
    total++;
    if (dout_a !== 8'h00 || ok_a !== 1'b0 || ovf_a !== 1'b0 || perr_a !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs: dout=%h ok=%b ovf=%b perr=%0d, want 00 0 0 0", dout_a, ok_a, ovf_a, perr_a);
    end
    eor = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_latency();
    logic [2:0] seen;
    do_reset();
    d = 8'hA5; dvd = 1'b1; eor = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      seen[i] = empty_a;
    end
    total++;
    if (seen !== 3'b011) begin
      bad++;
      $display("FAIL latency: empty after edges 1..3 = %b%b%b, want 1 1 0", seen[0], seen[1], seen[2]);
    end
    total++;
    if (dout_a !== 8'hA5 || ok_a !== 1'b1 || count_a !== 4'd1) begin
      bad++;
      $display("FAIL first_byte: dout=%h ok=%b count=%0d, want a5 1 1", dout_a, ok_a, count_a);
    end
    repeat (6) step();
    total++;
    if (count_a !== 4'd1) begin
      bad++;
      $display("FAIL long_eor: count=%0d, want 1", count_a);
    end
    eor = 1'b0;
    step();
    step();
    pop();
    total++;
    if (empty_a !== 1'b1 || count_a !== 4'd0) begin
      bad++;
      $display("FAIL pop_single: empty=%b count=%0d, want 1 0", empty_a, count_a);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 8; i++) send_byte(8'(i), 1'b1, 1'b0, 1'b0);
    total++;
    if (full_a !== 1'b1 || count_a !== 4'd8 || ovf_a !== 1'b0) begin
      bad++;
      $display("FAIL fill8: full=%b count=%0d ovf=%b, want 1 8 0", full_a, count_a, ovf_a);
    end
    send_byte(8'h08, 1'b1, 1'b0, 1'b0);
    total++;
    if (ovf_a !== 1'b1 || count_a !== 4'd8) begin
      bad++;
      $display("FAIL overflow: ovf=%b count=%0d, want 1 8", ovf_a, count_a);
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (dout_a !== 8'(i) || empty_a !== 1'b0) begin
        bad++;
        $display("FAIL drain[%0d]: dout=%h empty=%b, want %h 0", i, dout_a, empty_a, 8'(i));
      end
      pop();
    end
    total++;
    if (empty_a !== 1'b1 || ovf_a !== 1'b1) begin
      bad++;
      $display("FAIL drained: empty=%b ovf=%b, want 1 1 (08 lost)", empty_a, ovf_a);
    end
  endtask

  task automatic test_full_rw();
    do_reset();
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1'b1, 1'b0, 1'b0);
    send_byte(8'h99, 1'b1, 1'b1, 1'b0);
    total++;
    if (count_a !== 4'd8 || full_a !== 1'b1 || ovf_a !== 1'b0 || dout_a !== 8'h11) begin
      bad++;
      $display("FAIL full_rw: count=%0d full=%b ovf=%b head=%h, want 8 1 0 11", count_a, full_a, ovf_a, dout_a);
    end
    repeat (7) pop();
    total++;
    if (dout_a !== 8'h99 || count_a !== 4'd1) begin
      bad++;
      $display("FAIL full_rw_tail: dout=%h count=%0d, want 99 1", dout_a, count_a);
    end
  endtask

  task automatic test_parity();
    do_reset();
    send_byte(8'h3C, 1'b0, 1'b0, 1'b0);
    total++;
    if (count_a !== 4'd1 || dout_a !== 8'h3C || ok_a !== 1'b0 || perr_a !== 8'd1) begin
      bad++;
      $display("FAIL bad_keep: count=%0d dout=%h ok=%b perr=%0d, want 1 3c 0 1", count_a, dout_a, ok_a, perr_a);
    end
    total++;
    if (empty_b !== 1'b1 || count_b !== 4'd0 || perr_b !== 8'd1) begin
      bad++;
      $display("FAIL bad_drop: empty=%b count=%0d perr=%0d, want 1 0 1", empty_b, count_b, perr_b);
    end
  endtask

  task automatic test_clear_wrap();
    do_reset();
    for (int i = 0; i < 9; i++) send_byte(8'h20 + 8'(i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(8'hE0, 1'b0, 1'b0, 1'b0);
    total++;
    if (ovf_a !== 1'b1 || perr_a !== 8'd5) begin
      bad++;
      $display("FAIL pre_clr: ovf=%b perr=%0d, want 1 5", ovf_a, perr_a);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    total++;
    if (ovf_a !== 1'b0 || perr_a !== 8'd0 || count_a !== 4'd8) begin
      bad++;
      $display("FAIL clr: ovf=%b perr=%0d count=%0d, want 0 0 8", ovf_a, perr_a, count_a);
    end
    send_byte(8'hE1, 1'b0, 1'b0, 1'b1);
    total++;
    if (ovf_a !== 1'b1 || perr_a !== 8'd1) begin
      bad++;
      $display("FAIL clr_vs_event: ovf=%b perr=%0d, want 1 1", ovf_a, perr_a);
    end
    repeat (8) pop();
    pop();
    total++;
    if (empty_a !== 1'b1 || count_a !== 4'd0 || full_a !== 1'b0) begin
      bad++;
      $display("FAIL rd_empty: empty=%b count=%0d full=%b, want 1 0 0", empty_a, count_a, full_a);
    end
    send_byte(8'h3F, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      send_byte(8'h40 + 8'(i), 1'b1, 1'b0, 1'b0);
      total++;
      if (count_a !== 4'd2 || dout_a !== 8'h3F + 8'(i)) begin
        bad++;
        $display("FAIL wrap[%0d]: count=%0d head=%h, want 2 %h", i, count_a, dout_a, 8'h3F + 8'(i));
      end
      pop();
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_overflow();
    test_full_rw();
    test_parity();
    test_clear_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
